// File: rtl/gfx_fill_rect.sv
// Rectangle-fill engine: streams one framebuffer write per pixel of a latched rectangle, raster order.
// Optional clipping to the screen edges is enabled by defining GFX_FILL_CLIP_EN.
module gfx_fill_rect #(
  parameter int SCREEN_WIDTH  = 320,
  parameter int SCREEN_HEIGHT = 240,
  parameter int ADDR_WIDTH    = 17,
  parameter int PIXEL_WIDTH   = 8,
  localparam int XW = $clog2(SCREEN_WIDTH),
  localparam int YW = $clog2(SCREEN_HEIGHT)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [XW-1:0]          rectX,
  input  logic [YW-1:0]          rectY,
  input  logic [XW:0]            rectW,
  input  logic [YW:0]            rectH,
  input  logic [PIXEL_WIDTH-1:0] color,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [ADDR_WIDTH-1:0]  memoryAddress,
  output logic [PIXEL_WIDTH-1:0] memoryWriteData,
  output logic                   memoryWriteRequest,
  input  logic                   memoryWriteComplete
);

  typedef enum logic [1:0] {IDLE, SETUP, WRITE, DONE} state_t;

  localparam logic [XW+1:0]         SW_X   = (XW+2)'(SCREEN_WIDTH);
  localparam logic [YW+1:0]         SH_Y   = (YW+2)'(SCREEN_HEIGHT);
  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(SCREEN_WIDTH);

  state_t                  state_q, state_d;
  logic [XW-1:0]           x0_q, x0_d;
  logic [XW-1:0]           x_q, x_d;
  logic [XW-1:0]           xLast_q, xLast_d;
  logic [YW-1:0]           y_q, y_d;
  logic [YW-1:0]           yLast_q, yLast_d;
  logic [XW:0]             w_q, w_d;
  logic [YW:0]             h_q, h_d;
  logic [PIXEL_WIDTH-1:0]  color_q, color_d;
  logic [ADDR_WIDTH-1:0]   rowBase_q, rowBase_d;
  logic                    err_q, err_d;

  // Rectangle extents, evaluated in SETUP while y_q still holds the top row.
  logic [XW+1:0] xEnd, xEndC;
  logic [YW+1:0] yEnd, yEndC;
  logic          offScreen, zeroArea, reject;

  assign xEnd      = {2'b00, x0_q} + {1'b0, w_q};
  assign yEnd      = {2'b00, y_q} + {1'b0, h_q};
  assign offScreen = ({2'b00, x0_q} >= SW_X) || ({2'b00, y_q} >= SH_Y);

`ifdef GFX_FILL_CLIP_EN
  assign xEndC    = (xEnd > SW_X) ? SW_X : xEnd;
  assign yEndC    = (yEnd > SH_Y) ? SH_Y : yEnd;
  assign reject   = 1'b0;
  assign zeroArea = offScreen || (w_q == '0) || (h_q == '0);
`else
  assign xEndC    = xEnd;
  assign yEndC    = yEnd;
  assign reject   = offScreen || (xEnd > SW_X) || (yEnd > SH_Y);
  assign zeroArea = (w_q == '0) || (h_q == '0);
`endif

  assign memoryAddress   = rowBase_q + ADDR_WIDTH'(x_q);
  assign memoryWriteData = color_q;

  always_comb begin
    state_d   = state_q;
    x0_d      = x0_q;
    x_d       = x_q;
    xLast_d   = xLast_q;
    y_d       = y_q;
    yLast_d   = yLast_q;
    w_d       = w_q;
    h_d       = h_q;
    color_d   = color_q;
    rowBase_d = rowBase_q;
    err_d     = err_q;

    busy               = (state_q != IDLE);
    done               = (state_q == DONE);
    error              = (state_q == DONE) && err_q;
    memoryWriteRequest = (state_q == WRITE);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          x0_d    = rectX;
          x_d     = rectX;
          y_d     = rectY;
          w_d     = rectW;
          h_d     = rectH;
          color_d = color;
          err_d   = 1'b0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        err_d = reject;
        if (reject || zeroArea) begin
          state_d = DONE;
        end else begin
          xLast_d   = XW'(xEndC - (XW+2)'(1));
          yLast_d   = YW'(yEndC - (YW+2)'(1));
          rowBase_d = ADDR_WIDTH'(y_q) * STRIDE;
          state_d   = WRITE;
        end
      end
      WRITE: begin
        if (memoryWriteComplete) begin
          if (x_q == xLast_q) begin
            x_d = x0_q;
            // Row base is left on the final row so it never walks past the screen.
            if (y_q == yLast_q) begin
              state_d = DONE;
            end else begin
              y_d       = y_q + 1'b1;
              rowBase_d = rowBase_q + STRIDE;
            end
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      x0_q      <= '0;
      x_q       <= '0;
      xLast_q   <= '0;
      y_q       <= '0;
      yLast_q   <= '0;
      w_q       <= '0;
      h_q       <= '0;
      color_q   <= '0;
      rowBase_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      x0_q      <= x0_d;
      x_q       <= x_d;
      xLast_q   <= xLast_d;
      y_q       <= y_d;
      yLast_q   <= yLast_d;
      w_q       <= w_d;
      h_q       <= h_d;
      color_q   <= color_d;
      rowBase_q <= rowBase_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_gfx_fill_rect.sv
// Directed bench for gfx_fill_rect: arbiter model with configurable wait states and per-scenario checks.
module tb_gfx_fill_rect;
  localparam int SW = 320;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [8:0]  rectX;
  logic [7:0]  rectY;
  logic [9:0]  rectW;
  logic [8:0]  rectH;
  logic [7:0]  color;
  logic        busy, done, error;
  logic [16:0] addr;
  logic [7:0]  wdata;
  logic        req;
  logic        complete;

  int checks   = 0;
  int failures = 0;

  int nwrites, addr_err, data_err, hold_err, drop_err;
  int done_cnt, done_k, first_req_k, busy_after, busy1_bad, timed_out;
  logic err_at_done;
  logic [16:0] wa [0:7];

  gfx_fill_rect dut (
    .clock              (clk),
    .reset              (rst_n),
    .start              (start),
    .rectX              (rectX),
    .rectY              (rectY),
    .rectW              (rectW),
    .rectH              (rectH),
    .color              (color),
    .busy               (busy),
    .done               (done),
    .error              (error),
    .memoryAddress      (addr),
    .memoryWriteData    (wdata),
    .memoryWriteRequest (req),
    .memoryWriteComplete(complete)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one command and plays the arbiter until the cycle after done.
  // Each pixel is held gap+1 cycles; complete is also raised while request is low.
  task automatic run_cmd(input int x, input int y, input int w, input int h, input logic [7:0] col,
                         input int gap, input int ex0, input int ey0, input int ew,
                         input int restart_k, input int budget);
    int k, wc, ex, ey;
    logic prev_req, prev_cmp, cmp;
    logic [16:0] prev_addr, exp_a;
    bit fin;
    nwrites = 0; addr_err = 0; data_err = 0; hold_err = 0; drop_err = 0;
    done_cnt = 0; done_k = -1; first_req_k = -1; busy_after = -1; busy1_bad = 0;
    err_at_done = 1'bx;
    for (int i = 0; i < 8; i++) wa[i] = '1;
    @(negedge clk);
    rectX = 9'(x); rectY = 8'(y); rectW = 10'(w); rectH = 9'(h); color = col;
    start = 1'b1; complete = 1'b0;
    @(negedge clk);
    start = 1'b0;
    k = 1; wc = 0; ex = 0; ey = 0; prev_req = 1'b0; prev_cmp = 1'b0; prev_addr = '0; fin = 0;
    while (!fin && k <= budget) begin
      if (k == 1 && busy !== 1'b1) busy1_bad = 1;
      if (done_cnt > 0 && k == done_k + 1) begin
        busy_after = int'(busy);
        fin = 1;
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_k = k;
        err_at_done = error;
      end
      if (req === 1'b1) begin
        if (first_req_k < 0) first_req_k = k;
        if (prev_req && !prev_cmp && addr !== prev_addr) hold_err++;
        if (wc == gap) begin
          cmp = 1'b1; wc = 0;
          exp_a = 17'((ey0 + ey) * SW + ex0 + ex);
          if (addr !== exp_a) addr_err++;
          if (wdata !== col) data_err++;
          if (nwrites < 8) wa[nwrites] = addr;
          nwrites++;
          ex++;
          if (ex == ew) begin ex = 0; ey++; end
        end else begin
          cmp = 1'b0; wc++;
        end
      end else begin
        cmp = 1'b1;
        if (first_req_k >= 0 && done_cnt == 0) drop_err++;
      end
      prev_req = req; prev_cmp = cmp; prev_addr = addr;
      complete = cmp;
      if (k == restart_k) begin
        rectX = 9'd0; rectY = 8'd0; rectW = 10'd2; rectH = 9'd2; color = 8'hEE;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    complete = 1'b0;
    start = 1'b0;
    timed_out = fin ? 0 : 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; complete = 1'b0;
    rectX = '0; rectY = '0; rectW = '0; rectH = '0; color = '0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL reset_error got=%b want=0", error); end
    checks++; if (req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b want=0", req); end
    checks++; if (addr !== 17'd0) begin failures++; $display("FAIL reset_addr got=%0d want=0", addr); end
    checks++; if (wdata !== 8'd0) begin failures++; $display("FAIL reset_data got=%0h want=0", wdata); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_clear();
    run_cmd(0, 0, 320, 240, 8'h5A, 0, 0, 0, 320, -1, 80000);
    checks++; if (timed_out !== 0) begin failures++; $display("FAIL clear_timeout got=%0d want=0", timed_out); end
    checks++; if (nwrites !== 76800) begin failures++; $display("FAIL clear_writes got=%0d want=76800", nwrites); end
    checks++; if (addr_err !== 0) begin failures++; $display("FAIL clear_addr_seq got=%0d bad want=0", addr_err); end
    checks++; if (data_err !== 0) begin failures++; $display("FAIL clear_data got=%0d bad want=0", data_err); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL clear_done_count got=%0d want=1", done_cnt); end
    checks++; if (err_at_done !== 1'b0) begin failures++; $display("FAIL clear_error got=%b want=0", err_at_done); end
    checks++; if (first_req_k !== 2) begin failures++; $display("FAIL clear_first_req got=%0d want=2", first_req_k); end
    checks++; if (done_k !== 76802) begin failures++; $display("FAIL clear_done_cycle got=%0d want=76802", done_k); end
    checks++; if (busy_after !== 0) begin failures++; $display("FAIL clear_busy_after got=%0d want=0", busy_after); end
    checks++; if (drop_err !== 0) begin failures++; $display("FAIL clear_req_drop got=%0d want=0", drop_err); end
  endtask

  task automatic test_stride_wait();
    logic [16:0] exp_tab [0:5];
    exp_tab[0] = 17'd6410; exp_tab[1] = 17'd6411; exp_tab[2] = 17'd6412;
    exp_tab[3] = 17'd6730; exp_tab[4] = 17'd6731; exp_tab[5] = 17'd6732;
    run_cmd(10, 20, 3, 2, 8'hC3, 2, 10, 20, 3, -1, 200);
    checks++; if (nwrites !== 6) begin failures++; $display("FAIL stride_writes got=%0d want=6", nwrites); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (wa[i] !== exp_tab[i]) begin failures++; $display("FAIL stride_addr%0d got=%0d want=%0d", i, wa[i], exp_tab[i]); end
    end
    checks++; if (hold_err !== 0) begin failures++; $display("FAIL stride_hold got=%0d want=0", hold_err); end
    checks++; if (drop_err !== 0) begin failures++; $display("FAIL stride_req_drop got=%0d want=0", drop_err); end
    checks++; if (busy1_bad !== 0) begin failures++; $display("FAIL stride_busy_setup got=%0d want=0", busy1_bad); end
    checks++; if (done_k !== 20) begin failures++; $display("FAIL stride_done_cycle got=%0d want=20", done_k); end
    checks++; if (data_err !== 0) begin failures++; $display("FAIL stride_data got=%0d want=0", data_err); end
  endtask

  task automatic test_edge_clip();
`ifdef GFX_FILL_CLIP_EN
    run_cmd(318, 239, 5, 4, 8'h11, 0, 318, 239, 2, -1, 100);
    checks++; if (nwrites !== 2) begin failures++; $display("FAIL clip_writes got=%0d want=2", nwrites); end
    checks++; if (wa[0] !== 17'd76798) begin failures++; $display("FAIL clip_addr0 got=%0d want=76798", wa[0]); end
    checks++; if (wa[1] !== 17'd76799) begin failures++; $display("FAIL clip_addr1 got=%0d want=76799", wa[1]); end
    checks++; if (err_at_done !== 1'b0) begin failures++; $display("FAIL clip_error got=%b want=0", err_at_done); end
    checks++; if (done_k !== 4) begin failures++; $display("FAIL clip_done_cycle got=%0d want=4", done_k); end
`else
    run_cmd(318, 239, 5, 4, 8'h11, 0, 318, 239, 0, -1, 100);
    checks++; if (nwrites !== 0) begin failures++; $display("FAIL clip_writes got=%0d want=0", nwrites); end
    checks++; if (err_at_done !== 1'b1) begin failures++; $display("FAIL clip_error got=%b want=1", err_at_done); end
    checks++; if (done_k !== 2) begin failures++; $display("FAIL clip_done_cycle got=%0d want=2", done_k); end
    checks++; if (first_req_k !== -1) begin failures++; $display("FAIL clip_req got=%0d want=-1", first_req_k); end
`endif
  endtask

  task automatic test_zero_area();
    run_cmd(5, 5, 0, 3, 8'h22, 0, 5, 5, 0, -1, 50);
    checks++; if (done_k !== 2) begin failures++; $display("FAIL zero_done_cycle got=%0d want=2", done_k); end
    checks++; if (nwrites !== 0) begin failures++; $display("FAIL zero_writes got=%0d want=0", nwrites); end
    checks++; if (first_req_k !== -1) begin failures++; $display("FAIL zero_req got=%0d want=-1", first_req_k); end
    checks++; if (err_at_done !== 1'b0) begin failures++; $display("FAIL zero_error got=%b want=0", err_at_done); end
    checks++; if (busy1_bad !== 0) begin failures++; $display("FAIL zero_busy_setup got=%0d want=0", busy1_bad); end
    checks++; if (busy_after !== 0) begin failures++; $display("FAIL zero_busy_after got=%0d want=0", busy_after); end
  endtask

  task automatic test_back_to_back();
    run_cmd(100, 50, 4, 4, 8'h3C, 1, 100, 50, 4, 3, 200);
    checks++; if (nwrites !== 16) begin failures++; $display("FAIL busy_start_writes got=%0d want=16", nwrites); end
    checks++; if (addr_err !== 0) begin failures++; $display("FAIL busy_start_addr got=%0d want=0", addr_err); end
    checks++; if (data_err !== 0) begin failures++; $display("FAIL busy_start_data got=%0d want=0", data_err); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL busy_start_done got=%0d want=1", done_cnt); end
    repeat (3) @(negedge clk);
    checks++; if (req !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL busy_start_queued got=req%b/busy%b want=0/0", req, busy);
    end
  endtask

  task automatic test_reset_mid_write();
    @(negedge clk);
    rectX = 9'd0; rectY = 8'd0; rectW = 10'd8; rectH = 9'd8; color = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; complete = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (req !== 1'b1) begin failures++; $display("FAIL midrst_pre_req got=%b want=1", req); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b want=0", busy); end
    checks++; if (req !== 1'b0) begin failures++; $display("FAIL midrst_req got=%b want=0", req); end
    checks++; if (addr !== 17'd0) begin failures++; $display("FAIL midrst_addr got=%0d want=0", addr); end
    checks++; if (wdata !== 8'd0) begin failures++; $display("FAIL midrst_data got=%0h want=0", wdata); end
    checks++; if (done !== 1'b0 || error !== 1'b0) begin
      failures++; $display("FAIL midrst_done_err got=%b%b want=00", done, error);
    end
    complete = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_cmd(0, 0, 1, 1, 8'h77, 0, 0, 0, 1, -1, 50);
    checks++; if (nwrites !== 1) begin failures++; $display("FAIL midrst_writes got=%0d want=1", nwrites); end
    checks++; if (wa[0] !== 17'd0) begin failures++; $display("FAIL midrst_addr0 got=%0d want=0", wa[0]); end
    checks++; if (done_k !== 3) begin failures++; $display("FAIL midrst_done_cycle got=%0d want=3", done_k); end
  endtask

  initial begin
    test_reset();
    test_full_clear();
    test_stride_wait();
    test_edge_clip();
    test_zero_area();
    test_back_to_back();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
